// File: rtl/object_mouse_drag.sv
// Mouse-driven object mover: accumulates signed PS/2 displacement packets and
// applies them to a clamped or wrapped on-screen position once per move tick.
module object_mouse_drag #(
    parameter int POS_W     = 10,
    parameter int VEL_W     = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SHIFT     = 0,
    parameter int WRAP      = 0,
    parameter int DRAG_ONLY = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mouse_ready,
    input  logic [VEL_W-1:0] vx,
    input  logic [VEL_W-1:0] vy,
    input  logic             dx,
    input  logic             dy,
    input  logic             mouse_push,
    input  logic             move_tick,
    input  logic             load,
    input  logic [POS_W-1:0] width,
    input  logic [POS_W-1:0] height,
    input  logic [POS_W-1:0] init_x,
    input  logic [POS_W-1:0] init_y,
    output logic [POS_W-1:0] posx,
    output logic [POS_W-1:0] posy,
    output logic             dragging
);

    localparam int ACC_W = VEL_W + 2;
    localparam int N_W   = POS_W + ACC_W + 1;

    localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [N_W-1:0]   SCR_X   = N_W'(SCREEN_W);
    localparam logic signed [N_W-1:0]   SCR_Y   = N_W'(SCREEN_H);

    typedef enum logic {IDLE, DRAG} state_t;

    state_t                  state_q;
    logic                    dragging_q;
    logic                    init_pending_q;
    logic [POS_W-1:0]        posx_q, posx_d;
    logic [POS_W-1:0]        posy_q, posy_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic signed [ACC_W-1:0] base_x, base_y;
    logic                    accept;

    // Saturating signed add of one sign/magnitude packet component.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic [VEL_W-1:0]        mag,
        input logic                    neg
    );
        logic signed [ACC_W:0] step;
        logic signed [ACC_W:0] sum;
        step = $signed({3'b000, mag});
        if (neg)
            step = -step;
        sum = $signed({acc[ACC_W-1], acc}) + step;
        if (sum > SUM_MAX)
            sum = SUM_MAX;
        else if (sum < SUM_MIN)
            sum = SUM_MIN;
        return sum[ACC_W-1:0];
    endfunction

    // New coordinate after applying displacement d, clamped or wrapped to the screen.
    function automatic logic [POS_W-1:0] next_pos(
        input logic [POS_W-1:0]        pos,
        input logic signed [ACC_W-1:0] d,
        input logic [POS_W-1:0]        size,
        input logic signed [N_W-1:0]   scr
    );
        logic signed [N_W-1:0] dd;
        logic signed [N_W-1:0] n;
        logic signed [N_W-1:0] sz;
        logic signed [N_W-1:0] hi;
        logic signed [N_W-1:0] lim;
        dd  = {{(POS_W+1){d[ACC_W-1]}}, d};
        sz  = {{(ACC_W+1){1'b0}}, size};
        n   = {{(ACC_W+1){1'b0}}, pos};
        lim = scr - N_W'(1);
        hi  = '0;
        if (WRAP != 0) begin
            // A single wrap correction is only valid for |d| below one screen.
            if (dd > lim)
                dd = lim;
            else if (dd < -lim)
                dd = -lim;
            n = n + dd;
            if (n < 0)
                n = n + scr;
            else if (n >= scr)
                n = n - scr;
        end else begin
            n = n + dd;
            if (sz < scr)
                hi = scr - sz;
            if (n < 0)
                n = '0;
            else if (n > hi)
                n = hi;
        end
        return n[POS_W-1:0];
    endfunction

    // NOTE: every combinational output is given a default before any branch so no latch is inferred.
    always_comb begin
        accept  = mouse_ready && ((DRAG_ONLY == 0) || mouse_push);
        base_x  = move_tick ? '0 : acc_x_q;
        base_y  = move_tick ? '0 : acc_y_q;
        acc_x_d = accept ? sat_add(base_x, vx, dx) : base_x;
        acc_y_d = accept ? sat_add(base_y, vy, dy) : base_y;
        posx_d  = posx_q;
        posy_d  = posy_q;

        if (move_tick) begin
            posx_d = next_pos(posx_q, acc_x_q >>> SHIFT, width, SCR_X);
            posy_d = next_pos(posy_q, acc_y_q >>> SHIFT, height, SCR_Y);
        end

        if (load || init_pending_q) begin
            posx_d = init_x;
            posy_d = init_y;
        end

        if (load) begin
            acc_x_d = '0;
            acc_y_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            posx_q         <= '0;
            posy_q         <= '0;
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            init_pending_q <= 1'b1;
            state_q        <= IDLE;
            dragging_q     <= 1'b0;
        end else begin
            posx_q         <= posx_d;
            posy_q         <= posy_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            init_pending_q <= 1'b0;

            if (DRAG_ONLY == 0) begin
                state_q    <= DRAG;
                dragging_q <= 1'b1;
            end else if (load) begin
                state_q    <= IDLE;
                dragging_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (mouse_ready && mouse_push) begin
                        state_q    <= DRAG;
                        dragging_q <= 1'b1;
                    end
                    DRAG: if (mouse_ready && !mouse_push) begin
                        state_q    <= IDLE;
                        dragging_q <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        dragging_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign posx     = posx_q;
    assign posy     = posy_q;
    assign dragging = dragging_q;

endmodule

// File: tb/tb_object_mouse_drag.sv
// Directed bench for object_mouse_drag: clamp, shift/saturation and wrap variants
// share one stimulus stream; each step checks the instance it targets.
module tb_object_mouse_drag;

    logic       clk = 1'b0;
    logic       rstn;
    logic       mouse_ready, dx, dy, mouse_push, move_tick, load;
    logic [9:0] vx, vy, width, height, init_x, init_y;
    logic [9:0] a_posx, a_posy, s_posx, s_posy, w_posx, w_posy;
    logic       a_drag, s_drag, w_drag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    object_mouse_drag #(.SHIFT(0), .WRAP(0), .DRAG_ONLY(1)) u_a (
        .clk(clk), .rstn(rstn), .mouse_ready(mouse_ready), .vx(vx), .vy(vy), .dx(dx), .dy(dy),
        .mouse_push(mouse_push), .move_tick(move_tick), .load(load), .width(width), .height(height),
        .init_x(init_x), .init_y(init_y), .posx(a_posx), .posy(a_posy), .dragging(a_drag));

    object_mouse_drag #(.SHIFT(2), .WRAP(0), .DRAG_ONLY(1)) u_s (
        .clk(clk), .rstn(rstn), .mouse_ready(mouse_ready), .vx(vx), .vy(vy), .dx(dx), .dy(dy),
        .mouse_push(mouse_push), .move_tick(move_tick), .load(load), .width(width), .height(height),
        .init_x(init_x), .init_y(init_y), .posx(s_posx), .posy(s_posy), .dragging(s_drag));

    object_mouse_drag #(.SHIFT(0), .WRAP(1), .DRAG_ONLY(1)) u_w (
        .clk(clk), .rstn(rstn), .mouse_ready(mouse_ready), .vx(vx), .vy(vy), .dx(dx), .dy(dy),
        .mouse_push(mouse_push), .move_tick(move_tick), .load(load), .width(width), .height(height),
        .init_x(init_x), .init_y(init_y), .posx(w_posx), .posy(w_posy), .dragging(w_drag));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One packet lasting one clock; tk also raises move_tick on the same edge.
    task automatic pkt(input logic [9:0] ax, input logic sx, input logic [9:0] ay,
                       input logic sy, input logic push, input logic tk);
        @(negedge clk);
        vx = ax; dx = sx; vy = ay; dy = sy; mouse_push = push;
        mouse_ready = 1'b1; move_tick = tk;
        @(negedge clk);
        mouse_ready = 1'b0; move_tick = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic do_load(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        init_x = x; init_y = y; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; mouse_ready = 1'b0; move_tick = 1'b0; load = 1'b0;
        vx = '0; vy = '0; dx = 1'b0; dy = 1'b0; mouse_push = 1'b0;
        width = 10'd16; height = 10'd16; init_x = 10'd100; init_y = 10'd50;

        #1;
        check("reset_posx", a_posx, 0);
        check("reset_posy", a_posy, 0);
        check("reset_drag", a_drag, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("init_posx", a_posx, 100);
        check("init_posy", a_posy, 50);
        check("init_drag", a_drag, 0);
        check("init_drag_s", s_drag, 0);
        check("init_drag_w", w_drag, 0);

        // Drag gating
        pkt(10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        check("drag_enter", a_drag, 1);
        check("hold_no_tick", a_posx, 100);
        tick();
        check("drag_move", a_posx, 105);
        pkt(10'd7, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("drag_exit", a_drag, 0);
        tick();
        check("idle_no_move", a_posx, 105);

        // Clamp at both screen edges
        do_load(10'd630, 10'd470);
        pkt(10'd20, 1'b0, 10'd20, 1'b0, 1'b1, 1'b0);
        tick();
        check("clamp_hi_x", a_posx, 624);
        check("clamp_hi_y", a_posy, 464);
        pkt(10'd900, 1'b1, 10'd900, 1'b1, 1'b1, 1'b0);
        tick();
        check("clamp_lo_x", a_posx, 0);
        check("clamp_lo_y", a_posy, 0);

        // Object wider than the screen pins to 0
        width = 10'd700;
        do_load(10'd0, 10'd0);
        pkt(10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("wide_obj", a_posx, 0);
        width = 10'd16;

        // Saturation and shift
        do_load(10'd0, 10'd0);
        repeat (5) pkt(10'd1023, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sat_shift2", s_posx, 511);
        check("sat_shift2_y", s_posy, 0);
        check("sat_clamp", a_posx, 624);
        check("sat_wrap_lim", w_posx, 639);
        do_load(10'd100, 10'd0);
        pkt(10'd1, 1'b1, 10'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("shift_floor", s_posx, 99);

        // Wrap
        do_load(10'd635, 10'd0);
        pkt(10'd10, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("wrap_right", w_posx, 5);
        do_load(10'd3, 10'd5);
        pkt(10'd10, 1'b1, 10'd10, 1'b1, 1'b1, 1'b0);
        tick();
        check("wrap_left", w_posx, 633);
        check("wrap_up", w_posy, 475);

        // Packet coinciding with tick goes into the next interval
        do_load(10'd100, 10'd0);
        pkt(10'd4, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        pkt(10'd3, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
        check("coincide_1", a_posx, 104);
        tick();
        check("coincide_2", a_posx, 107);

        // Load wins over a simultaneous tick
        pkt(10'd9, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        init_x = 10'd300; load = 1'b1; move_tick = 1'b1;
        @(negedge clk);
        load = 1'b0; move_tick = 1'b0;
        check("load_vs_tick", a_posx, 300);
        tick();
        check("load_clears_acc", a_posx, 300);

        // Asynchronous reset mid-drag
        do_load(10'd200, 10'd0);
        pkt(10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_drag", a_drag, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_posx", a_posx, 0);
        check("async_rst_drag", a_drag, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reinit_posx", a_posx, 200);
        tick();
        check("rst_cleared_acc", a_posx, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
